vga_pixel_fetch: RTL and testbench



---
 rtl/display_pkg.sv | 21 ++
 rtl/pixel_fifo.sv | 56 +++++
 rtl/vga_pixel_fetch.sv | 130 +++++++++++++
 tb/tb_vga_pixel_fetch.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared display types and constants for the pixel fetch path and the VGA timing stage.
package display_pkg;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned V_ACTIVE = 480;

   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

   typedef enum logic [2:0] {
      StWaitVs,
      StFlush,
      StFetch,
      StDone,
      StDrain
   } fetch_state_e;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous show-ahead FIFO: head is valid whenever not empty and reads as zero when empty.
module pixel_fifo #(
   parameter int unsigned Width = 16,
   parameter int unsigned Depth = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [Width-1:0]           wdata,
   output logic [Width-1:0]           head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(Depth):0]     count
);

   localparam int unsigned AW = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;

   assign full    = (cnt_q == (AW+1)'(Depth));
   assign empty   = (cnt_q == '0);
   assign count   = cnt_q;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = empty ? '0 : mem_q[rd_q];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata;
   end

endmodule

// File: rtl/vga_pixel_fetch.sv
// Streams one frame of RGB565 words from the framebuffer into a show-ahead FIFO for the
// timing stage; a falling v_sync restarts the frame address.
module vga_pixel_fetch #(
   parameter int unsigned       ADDR_W     = 19,
   parameter logic [ADDR_W-1:0] FB_BASE    = '0,
   parameter int unsigned       H_ACTIVE   = display_pkg::H_ACTIVE,
   parameter int unsigned       V_ACTIVE   = display_pkg::V_ACTIVE,
   parameter int unsigned       FIFO_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              next_pixel,
   input  logic              v_sync,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [15:0]       mem_rdata,
   output logic [4:0]        pixel_red,
   output logic [5:0]        pixel_green,
   output logic [4:0]        pixel_blue,
   output logic              underrun
);

   import display_pkg::*;

   localparam int unsigned Total    = H_ACTIVE * V_ACTIVE;
   localparam int unsigned CntW     = $clog2(Total + 1);
   localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e      state_q, state_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              vs_q, underrun_q;
   logic              vs_fall, ack, push, flush;
   logic              fifo_full, fifo_empty;
   logic [FifoCntW-1:0] fifo_count;
   logic              unused_count;
   logic [15:0]       head;
   rgb565_t           px;

   assign vs_fall      = vs_q & ~v_sync;
   assign ack          = mem_ack & req_q;
   assign unused_count = ^fifo_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StWaitVs;
         req_q      <= 1'b0;
         addr_q     <= FB_BASE;
         cnt_q      <= '0;
         vs_q       <= 1'b1;
         underrun_q <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         vs_q    <= v_sync;
         if (next_pixel && fifo_empty) underrun_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      push    = 1'b0;
      flush   = 1'b0;
      unique case (state_q)
         StWaitVs, StDone: begin
            if (vs_fall) state_d = StFlush;
         end
         StFlush: begin
            flush   = 1'b1;
            addr_d  = FB_BASE;
            cnt_d   = '0;
            state_d = StFetch;
         end
         StFetch: begin
            if (vs_fall) begin
               // An in-flight read must complete before restarting; a coinciding ack is dropped.
               req_d   = req_q & ~ack;
               state_d = (req_q && !ack) ? StDrain : StFlush;
            end else if (ack) begin
               push   = 1'b1;
               req_d  = 1'b0;
               addr_d = addr_q + ADDR_W'(1);
               cnt_d  = cnt_q + CntW'(1);
               if (cnt_q + CntW'(1) == CntW'(Total)) state_d = StDone;
            end else if (!req_q && !fifo_full) begin
               req_d = 1'b1;
            end
         end
         StDrain: begin
            if (ack) begin
               req_d   = 1'b0;
               state_d = StFlush;
            end
         end
         default: state_d = StWaitVs;
      endcase
   end

   pixel_fifo #(
      .Width (16),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push),
      .pop   (next_pixel),
      .wdata (mem_rdata),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign px          = head;
   assign pixel_red   = px.r;
   assign pixel_green = px.g;
   assign pixel_blue  = px.b;
   assign mem_req     = req_q;
   assign mem_addr    = addr_q;
   assign underrun    = underrun_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed-sequence bench with a randomized framebuffer image; pixel k of a frame must equal
// the memory word at FB_BASE + k.
module tb_vga_pixel_fetch;
   import display_pkg::*;

   localparam int unsigned TH    = 32;
   localparam int unsigned TV    = 4;
   localparam int unsigned TOTAL = TH * TV;

   logic        clk = 1'b0;
   logic        rst, next_pixel, v_sync, mem_req, mem_ack, underrun;
   logic [18:0] mem_addr;
   logic [15:0] mem_rdata;
   logic [4:0]  pixel_red, pixel_blue;
   logic [5:0]  pixel_green;

   int          tests = 0;
   int          fails = 0;
   int unsigned ack_lat = 1;
   int unsigned mult = 1, salt = 0;
   logic        force_one = 1'b0;
   logic [18:0] addr_log[$];
   int          unstable_cnt = 0;

   vga_pixel_fetch #(
      .ADDR_W     (19),
      .FB_BASE    (19'h0),
      .H_ACTIVE   (TH),
      .V_ACTIVE   (TV),
      .FIFO_DEPTH (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .next_pixel  (next_pixel),
      .v_sync      (v_sync),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .pixel_red   (pixel_red),
      .pixel_green (pixel_green),
      .pixel_blue  (pixel_blue),
      .underrun    (underrun)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] data_of(input logic [18:0] a);
      logic [31:0] v;
      v = 32'(a) * mult + salt;
      return v[15:0] | {15'b0, force_one};
   endfunction

   function automatic logic [15:0] pix();
      return {pixel_red, pixel_green, pixel_blue};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Memory model: acks after ack_lat cycles of request; ack_lat == 0 toggles ack blindly.
   initial begin : responder
      int unsigned wcnt;
      logic [18:0] held;
      wcnt = 0;
      held = '0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (ack_lat == 0) begin
            mem_ack   = ~mem_ack;
            mem_rdata = 16'($urandom);
         end else if (mem_ack) begin
            mem_ack = 1'b0;
            wcnt = 0;
         end else if (mem_req) begin
            if (wcnt == 0) held = mem_addr;
            else if (mem_addr != held) unstable_cnt++;
            wcnt++;
            if (wcnt >= ack_lat) begin
               mem_ack   = 1'b1;
               mem_rdata = data_of(mem_addr);
               addr_log.push_back(mem_addr);
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   task automatic do_reset();
      rst = 1'b0;
      v_sync = 1'b1;
      next_pixel = 1'b0;
      @(negedge clk);
      check("rst_req", mem_req, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_px", pix(), 0);
      check("rst_underrun", underrun, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic vsync_pulse();
      v_sync = 1'b0;
      repeat (2) @(negedge clk);
      v_sync = 1'b1;
   endtask

   task automatic pop_check(input string tag, input logic [15:0] exp);
      check(tag, pix(), exp);
      next_pixel = 1'b1;
      @(negedge clk);
      next_pixel = 1'b0;
      @(negedge clk);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : main
      int base, dbase, k, zeros;
      logic found, prev;
      logic [18:0] held;
      rst = 1'b0;
      v_sync = 1'b1;
      next_pixel = 1'b0;

      // Idle after reset with spurious acks: nothing fetched, outputs zero.
      do_reset();
      ack_lat = 0;
      repeat (100) begin
         @(negedge clk);
         check("idle_req", mem_req, 0);
         check("idle_px", pix(), 0);
      end
      ack_lat = 1;
      repeat (3) @(negedge clk);
      check("idle_underrun", underrun, 0);

      // Prefetch fills the FIFO with address-valued words and stops requesting.
      base = addr_log.size();
      vsync_pulse();
      repeat (60) @(negedge clk);
      check("fill_cnt", 32'(addr_log.size() - base), 16);
      for (int i = 0; i < 16 && base + i < addr_log.size(); i++)
         check("fill_addr", addr_log[base+i], 32'(i));
      check("fill_stop", mem_req, 0);
      pop_check("first_pop", 16'h0000);
      check("second_b", pixel_blue, 1);
      pop_check("second_pop", 16'h0001);

      // Full frame at the 2-cycle pop cadence with a random image.
      do_reset();
      mult = $urandom | 1;
      salt = $urandom;
      base = addr_log.size();
      vsync_pulse();
      repeat (40) @(negedge clk);
      for (int i = 0; i < int'(TOTAL); i++) pop_check("frame_px", data_of(19'(i)));
      repeat (10) @(negedge clk);
      check("frame_words", 32'(addr_log.size() - base), TOTAL);
      for (int i = 0; i < int'(TOTAL) && base + i < addr_log.size(); i++)
         check("frame_addr", addr_log[base+i], 32'(i));
      check("frame_underrun", underrun, 0);
      check("frame_done", dut.state_q, StDone);
      check("frame_req_idle", mem_req, 0);
      check("frame_px_empty", pix(), 0);

      // Slow memory with a pop every cycle: underrun, zeros while empty, data in order.
      do_reset();
      force_one = 1'b1;
      mult = $urandom | 1;
      salt = $urandom;
      ack_lat = 4;
      v_sync = 1'b0;
      next_pixel = 1'b1;
      k = 0;
      zeros = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (c == 2) v_sync = 1'b1;
         if (pix() != 16'h0) begin
            check("ur_px", pix(), data_of(19'(k)));
            k++;
         end else begin
            zeros++;
         end
      end
      next_pixel = 1'b0;
      @(negedge clk);
      check("ur_flag", underrun, 1);
      check("ur_words", 32'(k >= 5), 1);
      check("ur_zero_seen", 32'(zeros > 10), 1);

      // v_sync falls mid-request: address held through ack, data discarded, restart at base.
      do_reset();
      mult = $urandom | 1;
      salt = $urandom;
      ack_lat = 3;
      base = addr_log.size();
      vsync_pulse();
      for (int c = 0; c < 300 && (addr_log.size() - base) < 5; c++) @(negedge clk);
      check("drain_prefill", 32'((addr_log.size() - base) >= 5), 1);
      found = 1'b0;
      prev = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk);
         #1;
         if (mem_req && !prev) begin
            found = 1'b1;
            break;
         end
         prev = mem_req;
      end
      check("drain_rise", found, 1);
      v_sync = 1'b0;
      held = mem_addr;
      dbase = addr_log.size();
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         if (!mem_req) break;
         check("drain_addr", mem_addr, held);
      end
      v_sync = 1'b1;
      check("drain_acked", 32'(addr_log.size() - dbase), 1);
      found = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (mem_req) begin
            found = 1'b1;
            break;
         end
      end
      check("drain_next_req", found, 1);
      check("drain_next_addr", mem_addr, 0);
      repeat (60) @(negedge clk);
      pop_check("drain_first_px", data_of(19'h0));
      check("stable_addr", 32'(unstable_cnt), 0);

      // Asynchronous reset while a request is outstanding.
      found = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk);
         #1;
         if (mem_req) begin
            found = 1'b1;
            break;
         end
      end
      check("arst_req_seen", found, 1);
      #2 rst = 1'b0;
      #1;
      check("arst_req", mem_req, 0);
      check("arst_px", pix(), 0);
      check("arst_state", dut.state_q, StWaitVs);
      @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      check("arst_idle", mem_req, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
